tmr: RTL and testbench

//  Free-running prescaled tick generator. While enabled, it counts clock cycles and

---
 rtl/tmr.sv | 43 ++++
 tb/tb_tmr.sv | 116 +++++++++++
 2 files changed

// File: rtl/tmr.sv
// Prescaled periodic tick generator: emits a registered one-cycle fire pulse
// every prescale_i enabled clock cycles; prescale_i of 0 or 1 fires every cycle.
module tmr #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] prescale_i,
  input  logic             enable_i,
  output logic             fire_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             fire_q, fire_d;

  // The >= compare wraps immediately if prescale_i drops below the running count.
  always_comb begin
    count_d = '0;
    fire_d  = 1'b0;
    if (enable_i) begin
      if (prescale_i <= WIDTH'(1)) begin
        fire_d = 1'b1;
      end else if (count_q >= prescale_i - WIDTH'(1)) begin
        fire_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      fire_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      fire_q  <= fire_d;
    end
  end

  assign fire_o = fire_q;

endmodule

// File: tb/tb_tmr.sv
// Directed bench for tmr: expected fire values are queued as each step is driven
// and popped for comparison one time unit after the following rising edge.
module tb_tmr;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] prescale;
  logic             enable;
  logic             fire;

  int   errors = 0;
  int   checks = 0;
  logic sb_q[$];

  tmr #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .prescale_i (prescale),
    .enable_i   (enable),
    .fire_o     (fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Queue the expected value, advance one edge, then pop and compare.
  task automatic step(input logic exp, input string tag);
    logic e;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(fire, e, tag);
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    prescale = 16'd5;
    #2;
    chk(fire, 1'b0, "reset_state");
    @(posedge clk);
    #1;
    chk(fire, 1'b0, "reset_held_edge");
    rst = 1'b0;

    // 1: disabled, never fires
    for (int i = 1; i <= 6; i++) step(1'b0, "t1_disabled");

    // 2: prescale 5, pulses after edges 5, 10, 15
    enable = 1'b1;
    for (int i = 1; i <= 15; i++) step((i % 5) == 0, $sformatf("t2_p5_edge%0d", i));

    // 3: prescale 1 and 0 fire every cycle
    prescale = 16'd1;
    for (int i = 1; i <= 4; i++) step(1'b1, "t3_p1");
    prescale = 16'd0;
    for (int i = 1; i <= 4; i++) step(1'b1, "t3_p0");

    // 4: enable gap aborts the period; a full period follows re-enable
    prescale = 16'd5;
    for (int i = 1; i <= 3; i++) step(1'b0, "t4_pre_gap");
    enable = 1'b0;
    for (int i = 1; i <= 2; i++) step(1'b0, "t4_gap");
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) step(i == 5, $sformatf("t4_reen_edge%0d", i));

    // 5: lowering prescale below the running count wraps on the next edge
    prescale = 16'd10;
    for (int i = 1; i <= 7; i++) step(1'b0, "t5_count_to_7");
    prescale = 16'd4;
    step(1'b1, "t5_lowered_fire");
    for (int i = 1; i <= 8; i++) step((i % 4) == 0, $sformatf("t5_p4_edge%0d", i));

    // 6: asynchronous reset while fire is high
    for (int i = 1; i <= 3; i++) step(1'b0, "t6_pre");
    step(1'b1, "t6_fire_high");
    #2;
    rst = 1'b1;
    #1;
    chk(fire, 1'b0, "t6_async_rst_drop");
    prescale = 16'd3;
    @(posedge clk);
    #1;
    chk(fire, 1'b0, "t6_rst_over_edge");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) step((i % 3) == 0, $sformatf("t6_p3_edge%0d", i));

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
